// File: rtl/register_file_pkg.sv
// Shared sizing defaults and control FSM encoding for the register file.
package register_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITING = 2'd1,
        DONE    = 2'd2
    } rf_state_t;

endpackage

// File: rtl/register_file_ctrl.sv
// Write-burst tracker: raises register_done for one cycle after each burst ends.
module register_file_ctrl
    import register_file_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      reg_write,
    output rf_state_t state,
    output logic      register_done
);

    // Disabling the block drops any burst in progress silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            register_done <= 1'b0;
        end else if (!en) begin
            state         <= IDLE;
            register_done <= 1'b0;
        end else begin
            register_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (reg_write) state <= WRITING;
                end
                WRITING: begin
                    if (!reg_write) begin
                        state         <= DONE;
                        register_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= reg_write ? WRITING : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/register_file.sv
// 2-read/1-write register file, r0 hardwired to zero, registered write-first reads.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              register_done
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]                regs [NREGS];
    logic                             wr_hit;
    logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]    rd_q;
    rf_state_t                        state;

    assign wr_hit     = en && reg_write && (write_reg != '0);
    assign rd_addr[0] = read_reg1;
    assign rd_addr[1] = read_reg2;
    assign read_data1 = rd_q[0];
    assign read_data2 = rd_q[1];

    // regs[0] only ever holds its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            for (int i = 1; i < NREGS; i++)
                if (write_reg == ADDR_W'(i)) regs[i] <= write_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q[p] <= '0;
            end else if (en) begin
                if (rd_addr[p] == '0)
                    rd_q[p] <= '0;
                else if (wr_hit && (write_reg == rd_addr[p]))
                    rd_q[p] <= write_data;
                else
                    rd_q[p] <= regs[rd_addr[p]];
            end
        end
    end

    register_file_ctrl u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .reg_write     (reg_write),
        .state         (state),
        .register_done (register_done)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: writes, bypass, r0, enable gating, async reset.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        reg_write;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1, read_data2;
    logic        register_done;

    int checks   = 0;
    int failures = 0;

    register_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .reg_write     (reg_write),
        .read_reg1     (read_reg1),
        .read_reg2     (read_reg2),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .register_done (register_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; reg_write = 1'b0;
        read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
        #12;
        chk("reset_rd1", read_data1, 0);
        chk("reset_rd2", read_data2, 0);
        chk("reset_done", {31'd0, register_done}, 0);
        tick();
        rst_n = 1'b1;

        // Scenario 1: all registers read zero after reset
        en = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_reg1 = 5'(a);
            read_reg2 = 5'(31 - a);
            tick();
            chk("s1_rd1", read_data1, 0);
            chk("s1_rd2", read_data2, 0);
            chk("s1_done", {31'd0, register_done}, 0);
        end

        // Scenario 2: 3-cycle burst to r1
        reg_write = 1'b1; write_reg = 5'd1; write_data = 32'd100;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("s2_done_during", {31'd0, register_done}, 0);
        end
        reg_write = 1'b0; read_reg1 = 5'd1;
        tick();
        chk("s2_done_pulse", {31'd0, register_done}, 1);
        chk("s2_rd_r1", read_data1, 100);
        tick();
        chk("s2_done_clear", {31'd0, register_done}, 0);

        // Scenario 3: r2=200, dual read
        reg_write = 1'b1; write_reg = 5'd2; write_data = 32'd200;
        tick();
        chk("s3_done_during", {31'd0, register_done}, 0);
        reg_write = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd2;
        tick();
        chk("s3_done_pulse", {31'd0, register_done}, 1);
        chk("s3_rd1", read_data1, 100);
        chk("s3_rd2", read_data2, 200);
        tick();
        chk("s3_done_clear", {31'd0, register_done}, 0);

        // Scenario 4: write to r0 discarded but still pulses done
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'd50; read_reg1 = 5'd0;
        tick();
        chk("s4_rd_r0_bypass", read_data1, 0);
        reg_write = 1'b0;
        tick();
        chk("s4_done_pulse", {31'd0, register_done}, 1);
        chk("s4_rd_r0", read_data1, 0);
        tick();
        chk("s4_done_clear", {31'd0, register_done}, 0);

        // Scenario 5: same-edge bypass on both ports
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd7;
        read_reg1 = 5'd3; read_reg2 = 5'd3;
        tick();
        chk("s5_bypass_rd1", read_data1, 7);
        chk("s5_bypass_rd2", read_data2, 7);
        reg_write = 1'b0;
        tick();
        chk("s5_done_pulse", {31'd0, register_done}, 1);
        tick();

        // en=0 blocks write, read update and done
        en = 1'b0; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd99;
        read_reg1 = 5'd1; read_reg2 = 5'd2;
        tick();
        tick();
        chk("s5_en0_rd1_hold", read_data1, 7);
        chk("s5_en0_rd2_hold", read_data2, 7);
        chk("s5_en0_done", {31'd0, register_done}, 0);
        en = 1'b1; reg_write = 1'b0; read_reg1 = 5'd3;
        tick();
        chk("s5_en0_no_write", read_data1, 7);
        chk("s5_en0_no_pulse", {31'd0, register_done}, 0);

        // Burst interrupted by en=0 gives no pulse
        reg_write = 1'b1; write_reg = 5'd4; write_data = 32'd44;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1; reg_write = 1'b0; read_reg1 = 5'd4;
        tick();
        chk("en_drop_no_pulse", {31'd0, register_done}, 0);
        chk("en_drop_r4", read_data1, 44);

        // Scenario 6: reset mid-burst
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'd55;
        read_reg1 = 5'd1; read_reg2 = 5'd2;
        tick();
        tick();
        chk("s6_pre_rd1", read_data1, 100);
        chk("s6_pre_rd2", read_data2, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_rd1", read_data1, 0);
        chk("s6_async_rd2", read_data2, 0);
        chk("s6_async_done", {31'd0, register_done}, 0);
        reg_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_no_pulse", {31'd0, register_done}, 0);
        for (int a = 0; a < 32; a++) begin
            read_reg1 = 5'(a);
            read_reg2 = 5'(31 - a);
            tick();
            chk("s6_clear_rd1", read_data1, 0);
            chk("s6_clear_rd2", read_data2, 0);
        end

        // First write after reset lands on the first enabled edge
        reg_write = 1'b1; write_reg = 5'd6; write_data = 32'd66; read_reg1 = 5'd6;
        tick();
        chk("post_rst_bypass", read_data1, 66);
        reg_write = 1'b0; read_reg2 = 5'd6;
        tick();
        chk("post_rst_done", {31'd0, register_done}, 1);
        chk("post_rst_r6", read_data2, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width, giving 2**ADDR_W registers (32 by default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: block enable.
REQ-006 SHALL have port reg_write, input, 1 bit: write request level.
REQ-007 SHALL have port read_reg1, input, ADDR_W bits: read address for port 1.
REQ-008 SHALL have port read_reg2, input, ADDR_W bits: read address for port 2.
REQ-009 SHALL have port write_reg, input, ADDR_W bits: write address.
REQ-010 SHALL have port write_data, input, DATA_W bits: write data.
REQ-011 SHALL have port read_data1, output, DATA_W bits: registered read data for port 1.
REQ-012 SHALL have port read_data2, output, DATA_W bits: registered read data for port 2.
REQ-013 SHALL have port register_done, output, 1 bit: one-cycle pulse marking the end of a write burst.

Function
REQ-014 Write: on each rising edge with en=1 and reg_write=1, SHALL store write_data into register write_reg.
- A request held for N cycles SHALL perform N writes.
- The last write SHALL win.
REQ-015 Register 0 SHALL be hardwired to zero.
- Writes to address 0 SHALL be discarded.
- Reads of address 0 SHALL return 0.
REQ-016 Reads: on each rising edge with en=1, read_data1/read_data2 SHALL load the contents of read_reg1/read_reg2.
- Latency: 1 cycle.
REQ-017 Same-edge write and read to the same nonzero address SHALL return the new write_data (write-first bypass).
- The bypass SHALL apply independently on both ports.
REQ-018 With en=0:
- No register writes and no read-output updates SHALL occur.
- The outputs SHALL hold their values.
- The FSM SHALL return to IDLE without asserting register_done.
REQ-019 The control FSM SHALL have the states IDLE, WRITING and DONE.
REQ-020 IDLE transitions: en&reg_write SHALL go to WRITING; otherwise the FSM SHALL stay in IDLE.
REQ-021 WRITING transitions: reg_write=1 SHALL stay in WRITING; reg_write=0 SHALL go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then go to WRITING if en&reg_write, else to IDLE.
REQ-023 register_done SHALL be a registered output equal to 1 exactly while the FSM is in DONE, and 0 otherwise.
REQ-024 register_done SHALL pulse for bursts addressed to register 0 as well.
REQ-025 A write burst of any length SHALL produce exactly one register_done pulse, on the first edge after reg_write falls.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
- all registers to 0;
- read_data1 and read_data2 to 0;
- register_done to 0;
- the FSM to IDLE.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no register_done pulse.
REQ-028 After reset release, the first write SHALL be accepted on the first rising edge with en=1 and reg_write=1.

Structure
REQ-029 DATA_W/ADDR_W defaults and the FSM state encoding (IDLE, WRITING, DONE) SHALL reside in a shared package, register_file_pkg.
REQ-030 The FSM and the done pulse SHALL be a sub-module, register_file_ctrl.
REQ-031 The storage array, write-first bypass and read registers SHALL be in the top level.

Verification
REQ-032 Scenario 1: after reset, read addresses 0..31 -> both read ports return 0 and register_done=0.
REQ-033 Scenario 2: with en=1, hold reg_write=1 for 3 cycles writing 100 to r1, then drop it -> register_done pulses once, 1 cycle after the fall; next-cycle read of r1 returns 100.
REQ-034 Scenario 3: write 200 to r2, then read r1 on port 1 and r2 on port 2 -> read_data1=100 and read_data2=200 one cycle later.
REQ-035 Scenario 4: write 50 to r0 -> register_done still pulses; a read of r0 returns 0.
REQ-036 Scenario 5: write 7 to r3 while reading r3 on the same edge -> read_data1=7 (bypass); with en=0 during a write request -> no change and no done pulse.
REQ-037 Scenario 6: assert rst_n=0 mid-burst -> outputs go to 0 asynchronously, no done pulse, and all registers read 0 afterwards.
